// File: rtl/moving_avg_filter.sv
// rtl/moving_avg_filter.sv - boxcar moving-average stage over the last 2^LOG2_N accepted samples
module moving_avg_filter #(
  parameter int Width  = 10,
  parameter int LOG2_N = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    clr,
  input  logic                    valid_in,
  input  logic signed [Width-1:0] data_in,
  output logic signed [Width-1:0] data_out,
  output logic                    valid_out,
  output logic                    primed
);

  localparam int N  = 1 << LOG2_N;
  localparam int SW = Width + LOG2_N;
  localparam logic [LOG2_N:0] FILL_LAST = (LOG2_N + 1)'(N - 1);

  typedef enum logic {FILL, RUN} state_e;

  state_e                  state_q, state_d;
  logic signed [Width-1:0] win_q [N];
  logic signed [Width-1:0] win_d [N];
  logic signed [SW-1:0]    sum_q, sum_d, sum_next;
  logic [LOG2_N-1:0]       wr_ptr_q, wr_ptr_d;
  logic [LOG2_N:0]         fill_cnt_q, fill_cnt_d;
  logic signed [Width-1:0] data_out_q, data_out_d;
  logic                    valid_out_q, valid_out_d;
  logic signed [Width-1:0] old_sample;

  // Sliding-window update: swap the oldest sample for the new one in the running sum.
  always_comb begin
    old_sample = win_q[wr_ptr_q];
    sum_next   = sum_q + {{LOG2_N{data_in[Width-1]}}, data_in}
                       - {{LOG2_N{old_sample[Width-1]}}, old_sample};
  end

  // Next-state logic: flush has priority, then accept, otherwise hold with no strobe.
  always_comb begin
    state_d     = state_q;
    win_d       = win_q;
    sum_d       = sum_q;
    wr_ptr_d    = wr_ptr_q;
    fill_cnt_d  = fill_cnt_q;
    data_out_d  = data_out_q;
    valid_out_d = 1'b0;
    if (clr) begin
      state_d    = FILL;
      win_d      = '{default: '0};
      sum_d      = '0;
      wr_ptr_d   = '0;
      fill_cnt_d = '0;
      data_out_d = '0;
    end else if (en && valid_in) begin
      win_d[wr_ptr_q] = data_in;
      wr_ptr_d        = wr_ptr_q + 1'b1;
      sum_d           = sum_next;
      case (state_q)
        FILL: begin
          fill_cnt_d = fill_cnt_q + 1'b1;
          if (fill_cnt_q == FILL_LAST) begin
            state_d     = RUN;
            valid_out_d = 1'b1;
            // Upper bits of the sum are the floor-divided average (arithmetic shift).
            data_out_d  = sum_next[SW-1:LOG2_N];
          end
        end
        RUN: begin
          valid_out_d = 1'b1;
          data_out_d  = sum_next[SW-1:LOG2_N];
        end
        default: state_d = FILL;
      endcase
    end
  end

  // State and datapath registers with asynchronous power-up clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FILL;
      win_q       <= '{default: '0};
      sum_q       <= '0;
      wr_ptr_q    <= '0;
      fill_cnt_q  <= '0;
      data_out_q  <= '0;
      valid_out_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      win_q       <= win_d;
      sum_q       <= sum_d;
      wr_ptr_q    <= wr_ptr_d;
      fill_cnt_q  <= fill_cnt_d;
      data_out_q  <= data_out_d;
      valid_out_q <= valid_out_d;
    end
  end

  assign data_out  = data_out_q;
  assign valid_out = valid_out_q;
  assign primed    = (state_q == RUN);

endmodule

// File: tb/tb_moving_avg_filter.sv
// tb/tb_moving_avg_filter.sv - self-checking bench for moving_avg_filter
module tb_moving_avg_filter;

  logic              clk;
  logic              rst_n;
  logic              en;
  logic              clr;
  logic              valid_in;
  logic signed [9:0] data_in;
  logic signed [9:0] data_out;
  logic              valid_out;
  logic              primed;

  moving_avg_filter #(.Width(10), .LOG2_N(3)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .clr      (clr),
    .valid_in (valid_in),
    .data_in  (data_in),
    .data_out (data_out),
    .valid_out(valid_out),
    .primed   (primed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: list of the most recent accepted samples (at most 8).
  int hist[$];
  int exp_data;
  int exp_valid;
  int exp_primed;

  typedef struct {
    logic en;
    logic clr;
    logic vin;
    int   d;
    int   ev;
    int   ed;
    int   ep;
  } vec_t;
  vec_t tbl[12];

  int outs[$];
  int strobes;

  function automatic int floor_div8(int s);
    if (s >= 0) return s / 8;
    return -((-s + 7) / 8);
  endfunction

  task automatic chk(string name, int act, int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    exp_data   = 0;
    exp_valid  = 0;
    exp_primed = 0;
  endtask

  // Apply one clock of stimulus, update the model, leave time at edge+1.
  task automatic drive(logic e, logic c, logic v, int d);
    int s;
    en       = e;
    clr      = c;
    valid_in = v;
    data_in  = 10'(d);
    @(posedge clk);
    #1;
    exp_valid = 0;
    if (c) begin
      hist.delete();
      exp_data = 0;
    end else if (e && v) begin
      hist.push_back(d);
      if (hist.size() > 8) void'(hist.pop_front());
      if (hist.size() == 8) begin
        s = 0;
        foreach (hist[i]) s += hist[i];
        exp_data  = floor_div8(s);
        exp_valid = 1;
      end
    end
    exp_primed = (hist.size() == 8) ? 1 : 0;
    en       = 1'b0;
    clr      = 1'b0;
    valid_in = 1'b0;
  endtask

  task automatic check_model(string name);
    chk({name, "_valid"},  int'(valid_out), exp_valid);
    chk({name, "_data"},   int'(data_out),  exp_data);
    chk({name, "_primed"}, int'(primed),    exp_primed);
  endtask

  task automatic step(logic e, logic c, logic v, int d, string name);
    drive(e, c, v, d);
    check_model(name);
    if (valid_out) begin
      strobes++;
      outs.push_back(int'(data_out));
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; clr = 1'b0; valid_in = 1'b0; data_in = '0;
    model_reset();
    strobes = 0;

    for (int i = 0; i < 7; i++) tbl[i] = '{1'b1, 1'b0, 1'b1, 8, 0, 0, 0};
    tbl[7]  = '{1'b1, 1'b0, 1'b1,   8, 1, 8, 1};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 100, 0, 8, 1};
    tbl[9]  = '{1'b1, 1'b0, 1'b0,  50, 0, 8, 1};
    tbl[10] = '{1'b1, 1'b1, 1'b1,   5, 0, 0, 0};
    tbl[11] = '{1'b1, 1'b0, 1'b1,   8, 0, 0, 0};

    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid",  int'(valid_out), 0);
    chk("reset_data",   int'(data_out),  0);
    chk("reset_primed", int'(primed),    0);
    rst_n = 1'b1;

    // Constant fill, enable hold and flush, table driven
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].en, tbl[i].clr, tbl[i].vin, tbl[i].d);
      chk($sformatf("tbl%0d_valid", i),  int'(valid_out), tbl[i].ev);
      chk($sformatf("tbl%0d_data", i),   int'(data_out),  tbl[i].ed);
      chk($sformatf("tbl%0d_primed", i), int'(primed),    tbl[i].ep);
    end

    // Contiguous ramp 0..19
    step(1, 1, 0, 0, "ramp_clr");
    strobes = 0; outs.delete();
    for (int k = 0; k < 20; k++) step(1, 0, 1, k, "ramp");
    chk("ramp_strobes", strobes, 13);
    for (int j = 0; j < outs.size() && j < 13; j++)
      chk($sformatf("ramp_out%0d", j), outs[j], j + 3);

    // Same ramp with sparse valid and an enable-low gap
    step(1, 1, 0, 0, "gap_clr");
    strobes = 0; outs.delete();
    for (int k = 0; k < 20; k++) begin
      step(1, 0, 1, k, "gap");
      if (k == 9) begin
        for (int g = 0; g < 3; g++) step(0, 0, 1, 300, "gap_en_low");
      end
      for (int g = 0; g < 3; g++) step(1, 0, 0, 0, "gap_idle");
    end
    chk("gap_strobes", strobes, 13);
    for (int j = 0; j < outs.size() && j < 13; j++)
      chk($sformatf("gap_out%0d", j), outs[j], j + 3);

    // Negative floor behaviour
    step(1, 1, 0, 0, "neg_clr");
    for (int k = 0; k < 8; k++) step(1, 0, 1, -3, "neg3");
    chk("neg3_final", int'(data_out), -3);
    for (int k = 0; k < 8; k++) step(1, 0, 1, (k % 2 == 0) ? -1 : 0, "negalt");
    chk("negalt_final", int'(data_out), -1);

    // Extremes of the sample range
    step(1, 1, 0, 0, "ext_clr");
    for (int k = 0; k < 8; k++) step(1, 0, 1, 511, "ext_max");
    chk("ext_max_final", int'(data_out), 511);
    for (int k = 0; k < 8; k++) step(1, 0, 1, -512, "ext_min");
    chk("ext_min_final", int'(data_out), -512);

    // Flush in RUN with a coincident sample, then refill
    step(1, 0, 1, 40, "run_more");
    step(0, 1, 1, 77, "clr_run");
    chk("clr_run_primed", int'(primed), 0);
    chk("clr_run_data",   int'(data_out), 0);
    strobes = 0;
    for (int k = 0; k < 7; k++) step(1, 0, 1, 10 * k, "refill");
    chk("refill_no_strobe", strobes, 0);
    step(1, 0, 1, 70, "refill_last");
    chk("refill_strobe", strobes, 1);

    // Asynchronous reset between edges
    step(1, 0, 1, 123, "pre_rst");
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid",  int'(valid_out), 0);
    chk("arst_data",   int'(data_out),  0);
    chk("arst_primed", int'(primed),    0);
    #1 rst_n = 1'b1;
    model_reset();
    for (int k = 0; k < 8; k++) step(1, 0, 1, -100 + 3 * k, "post_rst");

    // Randomized traffic against the model
    for (int k = 0; k < 400; k++) begin
      logic e, c, v;
      int d;
      e = ($urandom_range(0, 9) != 0);
      c = ($urandom_range(0, 49) == 0);
      v = ($urandom_range(0, 2) != 0);
      d = int'($urandom_range(0, 1023)) - 512;
      step(e, c, v, d, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
